// File: rtl/router_pkg.sv
// router_pkg
//   Shared definitions for the 1x3 router ingress controller:
//   - state_t         : ingress FSM states
//   - NUM_PORTS       : number of output FIFOs (fixed at 3)
//   - ADDR_W          : width of the destination address field
//   - ADDR_INVALID    : destination code that is silently dropped
//   - TIMEOUT_DEFAULT : unread cycles before an output FIFO is soft-reset
package router_pkg;

   localparam int             NUM_PORTS       = 3;
   localparam int             ADDR_W          = 2;
   localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;
   localparam int             TIMEOUT_DEFAULT = 30;

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      LOAD_FIRST_DATA    = 3'd1,
      LOAD_DATA          = 3'd2,
      LOAD_PARITY        = 3'd3,
      FIFO_FULL_STATE    = 3'd4,
      LOAD_AFTER_FULL    = 3'd5,
      WAIT_TILL_EMPTY    = 3'd6,
      CHECK_PARITY_ERROR = 3'd7
   } state_t;

endpackage

// File: rtl/router_timeout_ctr.sv
// router_timeout_ctr
//   Read-timeout watchdog for one output FIFO. Counts consecutive cycles in
//   which the FIFO holds data and is not read; on the TIMEOUT-th such cycle
//   it raises soft_reset_o for exactly one cycle and restarts the count.
// Ports:
//   clk, resetn   : clock, synchronous active-low reset
//   fifo_empty_i  : FIFO empty flag (empty means nothing to time out)
//   read_enb_i    : FIFO is being read this cycle
//   soft_reset_o  : registered one-cycle soft reset pulse
module router_timeout_ctr
   import router_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic resetn,
   input  logic fifo_empty_i,
   input  logic read_enb_i,
   output logic soft_reset_o
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sr_q, sr_d;

   // A read on the terminal-count cycle takes priority: the FIFO is being
   // serviced, so no pulse is produced and the count restarts.
   always_comb begin
      cnt_d = cnt_q;
      sr_d  = 1'b0;
      if (fifo_empty_i || read_enb_i) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
         cnt_d = '0;
         sr_d  = 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q <= '0;
         sr_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sr_q  <= sr_d;
      end
   end

   assign soft_reset_o = sr_q;

endmodule

// File: rtl/router_ctrl_fsm.sv
// router_ctrl_fsm
//   Packet-ingress controller for the 1x3 router. Sequences the byte/parity
//   datapath through header, payload, parity and full-stall phases, selects
//   and write-enables one of three output FIFOs, and runs one read-timeout
//   watchdog per output FIFO.
// Ports:
//   clk, resetn          : clock, synchronous active-low reset
//   pkt_valid, data_in   : input packet valid and destination address field
//   fifo_full/empty      : per-FIFO status flags
//   read_enb             : per-FIFO read enables from the output side
//   parity_done          : datapath has consumed the parity byte
//   low_pkt_valid        : packet ended while the FIFO was full
//   detect_add .. rst_int_reg : one-hot state decodes for the datapath
//   write_enb_reg        : datapath write phase
//   write_enb            : one-hot FIFO write enable
//   busy                 : stall to the input source
//   fifo_addr            : latched destination
//   soft_reset           : one-cycle per-FIFO soft reset pulse
module router_ctrl_fsm
   import router_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 pkt_valid,
   input  logic [ADDR_W-1:0]    data_in,
   input  logic [NUM_PORTS-1:0] fifo_full,
   input  logic [NUM_PORTS-1:0] fifo_empty,
   input  logic [NUM_PORTS-1:0] read_enb,
   input  logic                 parity_done,
   input  logic                 low_pkt_valid,
   output logic                 detect_add,
   output logic                 lfd_state,
   output logic                 ld_state,
   output logic                 laf_state,
   output logic                 full_state,
   output logic                 rst_int_reg,
   output logic                 write_enb_reg,
   output logic [NUM_PORTS-1:0] write_enb,
   output logic                 busy,
   output logic [ADDR_W-1:0]    fifo_addr,
   output logic [NUM_PORTS-1:0] soft_reset
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   // Flags padded to 4 entries so they can be indexed by any 2-bit address;
   // the invalid address reads as "not empty / not full / no soft reset".
   logic [3:0] empty_ext, full_ext, sr_ext;
   logic       hdr_ok, sel_full, abort;

   assign empty_ext = {1'b0, fifo_empty};
   assign full_ext  = {1'b0, fifo_full};
   assign sr_ext    = {1'b0, soft_reset};

   assign hdr_ok   = pkt_valid && (data_in != ADDR_INVALID);
   assign sel_full = full_ext[addr_q];
   // A watchdog firing on the FIFO we are writing kills the packet.
   assign abort    = sr_ext[addr_q] && (state_q != DECODE_ADDRESS);

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_wd
      router_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_wd (
         .clk          (clk),
         .resetn       (resetn),
         .fifo_empty_i (fifo_empty[g]),
         .read_enb_i   (read_enb[g]),
         .soft_reset_o (soft_reset[g])
      );
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      if (state_q == DECODE_ADDRESS && hdr_ok) begin
         addr_d = data_in;
      end
      if (abort) begin
         state_d = DECODE_ADDRESS;
      end else begin
         case (state_q)
            DECODE_ADDRESS: begin
               if (hdr_ok) begin
                  state_d = empty_ext[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
               end
            end
            WAIT_TILL_EMPTY:    if (empty_ext[addr_q]) state_d = LOAD_FIRST_DATA;
            LOAD_FIRST_DATA:    state_d = LOAD_DATA;
            LOAD_DATA: begin
               // Full takes priority over end-of-packet.
               if (sel_full)        state_d = FIFO_FULL_STATE;
               else if (!pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE:    if (!sel_full) state_d = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL: begin
               if (parity_done)        state_d = DECODE_ADDRESS;
               else if (low_pkt_valid) state_d = LOAD_PARITY;
               else                    state_d = LOAD_DATA;
            end
            LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = sel_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            default:            state_d = DECODE_ADDRESS;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= DECODE_ADDRESS;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   // Moore decodes
   always_comb begin
      detect_add    = (state_q == DECODE_ADDRESS);
      lfd_state     = (state_q == LOAD_FIRST_DATA);
      ld_state      = (state_q == LOAD_DATA);
      laf_state     = (state_q == LOAD_AFTER_FULL);
      full_state    = (state_q == FIFO_FULL_STATE);
      rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
      write_enb_reg = (state_q == LOAD_FIRST_DATA) || (state_q == LOAD_DATA) ||
                      (state_q == LOAD_PARITY)     || (state_q == LOAD_AFTER_FULL);
      busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));
      for (int i = 0; i < NUM_PORTS; i++) begin
         write_enb[i] = write_enb_reg && (addr_q == ADDR_W'(i));
      end
   end

   assign fifo_addr = addr_q;

endmodule

// File: tb/tb_router_ctrl_fsm.sv
module tb_router_ctrl_fsm;
   import router_pkg::*;

   logic       clk = 1'b0;
   logic       resetn;
   logic       pkt_valid;
   logic [1:0] data_in;
   logic [2:0] fifo_full, fifo_empty, read_enb;
   logic       parity_done, low_pkt_valid;
   logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
   logic       write_enb_reg, busy;
   logic [2:0] write_enb, soft_reset;
   logic [1:0] fifo_addr;

   int checks = 0;
   int errors = 0;

   router_ctrl_fsm #(.TIMEOUT(30)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .pkt_valid     (pkt_valid),
      .data_in       (data_in),
      .fifo_full     (fifo_full),
      .fifo_empty    (fifo_empty),
      .read_enb      (read_enb),
      .parity_done   (parity_done),
      .low_pkt_valid (low_pkt_valid),
      .detect_add    (detect_add),
      .lfd_state     (lfd_state),
      .ld_state      (ld_state),
      .laf_state     (laf_state),
      .full_state    (full_state),
      .rst_int_reg   (rst_int_reg),
      .write_enb_reg (write_enb_reg),
      .write_enb     (write_enb),
      .busy          (busy),
      .fifo_addr     (fifo_addr),
      .soft_reset    (soft_reset)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       pv;
      logic [1:0] din;
      logic [2:0] full;
      logic [2:0] empty;
      logic       pd;
      logic       lpv;
      state_t     st;
      logic [2:0] we;
      logic [1:0] addr;
   } vec_t;

   vec_t vecs[$];

   // Expected {detect_add, lfd, ld, laf, full, rst_int, write_enb_reg, busy}
   function automatic logic [7:0] exp_flags(state_t s);
      case (s)
         DECODE_ADDRESS:     return 8'b1000_0000;
         LOAD_FIRST_DATA:    return 8'b0100_0011;
         LOAD_DATA:          return 8'b0010_0010;
         LOAD_AFTER_FULL:    return 8'b0001_0011;
         FIFO_FULL_STATE:    return 8'b0000_1001;
         CHECK_PARITY_ERROR: return 8'b0000_0101;
         LOAD_PARITY:        return 8'b0000_0011;
         WAIT_TILL_EMPTY:    return 8'b0000_0001;
         default:            return 8'hxx;
      endcase
   endfunction

   task automatic add(input logic pv, input logic [1:0] din, input logic [2:0] full,
                      input logic [2:0] empty, input logic pd, input logic lpv,
                      input state_t st, input logic [2:0] we, input logic [1:0] addr);
      vec_t v;
      v.pv = pv; v.din = din; v.full = full; v.empty = empty; v.pd = pd; v.lpv = lpv;
      v.st = st; v.we = we; v.addr = addr;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic chk_state(input string name, input state_t st);
      chk({name, "_flags"},
          {24'd0, detect_add, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, write_enb_reg, busy}, {24'd0, exp_flags(st)});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 3'b000; fifo_empty = 3'b111;
      read_enb = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;
   endtask

   initial begin
      resetn = 1'b0;
      idle_inputs();

      // ---------------- reset ----------------
      tick();
      tick();
      chk_state("reset", DECODE_ADDRESS);
      chk("reset_we", {29'd0, write_enb}, 32'd0);
      chk("reset_sr", {29'd0, soft_reset}, 32'd0);
      chk("reset_addr", {30'd0, fifo_addr}, 32'd0);
      resetn = 1'b1;

      // ---------------- table ----------------
      // clean packet to addr 1
      add(1, 1, 3'b000, 3'b111, 0, 0, LOAD_FIRST_DATA,    3'b010, 1);
      add(1, 1, 3'b000, 3'b111, 0, 0, LOAD_DATA,          3'b010, 1);
      add(1, 1, 3'b000, 3'b111, 0, 0, LOAD_DATA,          3'b010, 1);
      add(1, 1, 3'b000, 3'b111, 0, 0, LOAD_DATA,          3'b010, 1);
      add(0, 0, 3'b000, 3'b111, 0, 0, LOAD_PARITY,        3'b010, 1);
      add(0, 0, 3'b000, 3'b111, 0, 0, CHECK_PARITY_ERROR, 3'b000, 1);
      add(0, 0, 3'b000, 3'b111, 0, 0, DECODE_ADDRESS,     3'b000, 1);
      // invalid address dropped, fifo_addr kept
      add(1, 3, 3'b000, 3'b111, 0, 0, DECODE_ADDRESS,     3'b000, 1);
      add(1, 3, 3'b000, 3'b111, 0, 0, DECODE_ADDRESS,     3'b000, 1);
      // busy destination 2
      add(1, 2, 3'b000, 3'b011, 0, 0, WAIT_TILL_EMPTY,    3'b000, 2);
      add(0, 0, 3'b000, 3'b011, 0, 0, WAIT_TILL_EMPTY,    3'b000, 2);
      add(0, 0, 3'b000, 3'b111, 0, 0, LOAD_FIRST_DATA,    3'b100, 2);
      add(1, 0, 3'b000, 3'b111, 0, 0, LOAD_DATA,          3'b100, 2);
      add(0, 0, 3'b000, 3'b111, 0, 0, LOAD_PARITY,        3'b100, 2);
      add(0, 0, 3'b000, 3'b111, 0, 0, CHECK_PARITY_ERROR, 3'b000, 2);
      add(0, 0, 3'b000, 3'b111, 0, 0, DECODE_ADDRESS,     3'b000, 2);
      // full stalls on addr 0
      add(1, 0, 3'b000, 3'b111, 0, 0, LOAD_FIRST_DATA,    3'b001, 0);
      add(1, 0, 3'b000, 3'b111, 0, 0, LOAD_DATA,          3'b001, 0);
      add(1, 0, 3'b001, 3'b111, 0, 0, FIFO_FULL_STATE,    3'b000, 0);
      add(1, 0, 3'b001, 3'b111, 0, 0, FIFO_FULL_STATE,    3'b000, 0);
      add(1, 0, 3'b000, 3'b111, 0, 0, LOAD_AFTER_FULL,    3'b001, 0);
      add(1, 0, 3'b000, 3'b111, 0, 0, LOAD_DATA,          3'b001, 0);
      add(1, 0, 3'b001, 3'b111, 0, 0, FIFO_FULL_STATE,    3'b000, 0);
      add(1, 0, 3'b000, 3'b111, 0, 0, LOAD_AFTER_FULL,    3'b001, 0);
      add(0, 0, 3'b000, 3'b111, 0, 1, LOAD_PARITY,        3'b001, 0);
      add(0, 0, 3'b000, 3'b111, 0, 0, CHECK_PARITY_ERROR, 3'b000, 0);
      add(0, 0, 3'b001, 3'b111, 0, 0, FIFO_FULL_STATE,    3'b000, 0);
      add(0, 0, 3'b000, 3'b111, 0, 0, LOAD_AFTER_FULL,    3'b001, 0);
      add(0, 0, 3'b000, 3'b111, 1, 1, DECODE_ADDRESS,     3'b000, 0);
      // full and end-of-packet together: full wins
      add(1, 0, 3'b000, 3'b111, 0, 0, LOAD_FIRST_DATA,    3'b001, 0);
      add(1, 0, 3'b000, 3'b111, 0, 0, LOAD_DATA,          3'b001, 0);
      add(0, 0, 3'b001, 3'b111, 0, 0, FIFO_FULL_STATE,    3'b000, 0);
      add(0, 0, 3'b000, 3'b111, 0, 0, LOAD_AFTER_FULL,    3'b001, 0);
      add(0, 0, 3'b000, 3'b111, 1, 0, DECODE_ADDRESS,     3'b000, 0);
      // full on non-selected ports does not stall
      add(1, 2, 3'b000, 3'b111, 0, 0, LOAD_FIRST_DATA,    3'b100, 2);
      add(1, 2, 3'b011, 3'b111, 0, 0, LOAD_DATA,          3'b100, 2);
      add(0, 0, 3'b011, 3'b111, 0, 0, LOAD_PARITY,        3'b100, 2);
      add(0, 0, 3'b000, 3'b111, 0, 0, CHECK_PARITY_ERROR, 3'b000, 2);
      add(0, 0, 3'b000, 3'b111, 0, 0, DECODE_ADDRESS,     3'b000, 2);

      for (int i = 0; i < vecs.size(); i++) begin
         pkt_valid = vecs[i].pv; data_in = vecs[i].din; fifo_full = vecs[i].full;
         fifo_empty = vecs[i].empty; parity_done = vecs[i].pd; low_pkt_valid = vecs[i].lpv;
         read_enb = 3'b000;
         tick();
         chk_state($sformatf("vec%0d", i), vecs[i].st);
         chk($sformatf("vec%0d_we", i), {29'd0, write_enb}, {29'd0, vecs[i].we});
         chk($sformatf("vec%0d_addr", i), {30'd0, fifo_addr}, {30'd0, vecs[i].addr});
         chk($sformatf("vec%0d_sr", i), {29'd0, soft_reset}, 32'd0);
      end
      idle_inputs();
      tick();

      // ---------------- reset mid-packet ----------------
      pkt_valid = 1'b1; data_in = 2'd2;
      tick();
      tick();
      chk_state("mid_ld", LOAD_DATA);
      resetn = 1'b0;
      tick();
      chk_state("mid_rst", DECODE_ADDRESS);
      chk("mid_rst_addr", {30'd0, fifo_addr}, 32'd0);
      chk("mid_rst_we", {29'd0, write_enb}, 32'd0);
      resetn = 1'b1;
      idle_inputs();
      tick();

      // ---------------- watchdog: plain timeout ----------------
      fifo_empty = 3'b101;
      for (int k = 1; k <= 31; k++) begin
         tick();
         chk($sformatf("wd1_k%0d", k), {29'd0, soft_reset}, (k == 30) ? 32'd2 : 32'd0);
      end
      fifo_empty = 3'b111;
      tick();

      // ---------------- watchdog: read on cycle 29 ----------------
      fifo_empty = 3'b101;
      for (int k = 1; k <= 60; k++) begin
         read_enb = (k == 29) ? 3'b010 : 3'b000;
         tick();
         chk($sformatf("wd2_k%0d", k), {29'd0, soft_reset}, (k == 59) ? 32'd2 : 32'd0);
      end
      idle_inputs();
      tick();

      // ---------------- watchdog: read on the terminal-count cycle ----------------
      fifo_empty = 3'b101;
      for (int k = 1; k <= 40; k++) begin
         read_enb = (k == 30) ? 3'b010 : 3'b000;
         tick();
         chk($sformatf("wd3_k%0d", k), {29'd0, soft_reset}, 32'd0);
      end
      idle_inputs();
      tick();

      // ---------------- watchdog aborts packet to addr 1 ----------------
      pkt_valid = 1'b1; data_in = 2'd1;
      tick();
      chk_state("ab_lfd", LOAD_FIRST_DATA);
      fifo_empty = 3'b101;
      for (int k = 1; k <= 31; k++) begin
         tick();
         if (k <= 30) chk_state($sformatf("ab_k%0d", k), LOAD_DATA);
         else         chk_state("ab_abort", DECODE_ADDRESS);
         chk($sformatf("ab_sr_k%0d", k), {29'd0, soft_reset}, (k == 30) ? 32'd2 : 32'd0);
      end
      idle_inputs();
      tick();
      chk_state("ab_idle", DECODE_ADDRESS);

      // ---------------- soft reset of non-selected port ----------------
      pkt_valid = 1'b1; data_in = 2'd0;
      tick();
      chk_state("ns_lfd", LOAD_FIRST_DATA);
      fifo_empty = 3'b011;
      for (int k = 1; k <= 31; k++) begin
         tick();
         chk_state($sformatf("ns_k%0d", k), LOAD_DATA);
         chk($sformatf("ns_sr_k%0d", k), {29'd0, soft_reset}, (k == 30) ? 32'd4 : 32'd0);
      end
      idle_inputs();
      tick();
      chk_state("ns_lp", LOAD_PARITY);
      tick();
      chk_state("ns_cpe", CHECK_PARITY_ERROR);
      tick();
      chk_state("ns_da", DECODE_ADDRESS);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
